// File: rtl/alu_pipe_if.sv
// Handshake and result bundle between operand fetch, the ALU stage and writeback.
// The slave view belongs to the ALU; the master view belongs to its neighbours.
interface alu_pipe_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             cout;
  logic             overflow;
  logic             negative;
  logic             zero;
  logic             illegal;
  logic             busy;

  modport master (
    output in_valid, opcode, a, b, cin, out_ready,
    input  in_ready, out_valid, y, cout, overflow, negative, zero, illegal, busy
  );

  modport slave (
    input  in_valid, opcode, a, b, cin, out_ready,
    output in_ready, out_valid, y, cout, overflow, negative, zero, illegal, busy
  );
endinterface

// File: rtl/alu_pipe.sv
// Registered ALU stage: single-cycle logic/shift/add ops, iterative shift-add MUL,
// one result held in output registers until writeback takes it.
module alu_pipe #(
  parameter int  WIDTH = 4,
  localparam int SHW   = $clog2(WIDTH) + 1
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_pipe_if.slave bus
);

  typedef enum logic [3:0] {
    OP_LL  = 4'b0000,
    OP_LR  = 4'b0001,
    OP_AR  = 4'b0010,
    OP_NOT = 4'b0011,
    OP_AND = 4'b0100,
    OP_OR  = 4'b0101,
    OP_XOR = 4'b0110,
    OP_ADD = 4'b0111,
    OP_SUB = 4'b1000,
    OP_MUL = 4'b1001
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_HOLD = 2'b10
  } state_e;

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             cout;
    logic             overflow;
    logic             illegal;
  } res_t;

  localparam logic [WIDTH-1:0] W_VAL     = WIDTH'(WIDTH);
  localparam logic [SHW-1:0]   LAST_STEP = SHW'(WIDTH - 1);

  state_e state, state_nx;
  logic   accept, load_alu, load_mul, start_mul;
  res_t   alu_res, mul_res, res_nx, res_q;
  logic   negative_q, zero_q;

  // ---------------------------------------------------------------- handshake
  assign bus.busy      = (state == S_MUL);
  assign bus.out_valid = (state == S_HOLD);
  assign bus.in_ready  = rst_n && (state != S_MUL) && ((state != S_HOLD) || bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;

  // ------------------------------------------------------ single-cycle datapath
  logic [SHW-1:0]          sh;
  logic                    sh_big;
  logic [WIDTH:0]          ll_ext, lr_ext, sum;
  logic signed [WIDTH:0]   ar_src, ar_ext;
  logic [WIDTH-1:0]        addend;

  // Shifts run one bit wider so the last bit shifted out lands in the spare bit.
  assign sh     = bus.b[SHW-1:0];
  assign sh_big = (bus.b >= W_VAL);
  assign ll_ext = {1'b0, bus.a} << sh;
  assign lr_ext = {bus.a, 1'b0} >> sh;
  assign ar_src = {bus.a, 1'b0};
  assign ar_ext = ar_src >>> sh;
  assign addend = (bus.opcode == OP_SUB) ? ~bus.b : bus.b;
  assign sum    = {1'b0, bus.a} + {1'b0, addend} + {{WIDTH{1'b0}}, bus.cin};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    alu_res = '0;
    case (bus.opcode)
      OP_LL:  if (!sh_big) {alu_res.cout, alu_res.y} = ll_ext;
      OP_LR:  if (!sh_big) {alu_res.y, alu_res.cout} = lr_ext;
      OP_AR: begin
        if (sh_big) alu_res.y = {WIDTH{bus.a[WIDTH-1]}};
        else        {alu_res.y, alu_res.cout} = ar_ext;
      end
      OP_NOT: alu_res.y = ~bus.a;
      OP_AND: alu_res.y = bus.a & bus.b;
      OP_OR:  alu_res.y = bus.a | bus.b;
      OP_XOR: alu_res.y = bus.a ^ bus.b;
      OP_ADD, OP_SUB: begin
        {alu_res.cout, alu_res.y} = sum;
        alu_res.overflow = (bus.a[WIDTH-1] == addend[WIDTH-1]) &&
                           (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_MUL: alu_res = '0;
      default: alu_res.illegal = 1'b1;
    endcase
  end

  // ------------------------------------------------------ iterative multiplier
  // Low half starts as the multiplier and drains one bit per step while the
  // partial product grows into the high half.
  logic [2*WIDTH-1:0] prod, prod_nx;
  logic [WIDTH-1:0]   mcand;
  logic [SHW-1:0]     step;
  logic [WIDTH:0]     partial;
  logic               hi_nz;

  assign partial = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
  assign prod_nx = {partial, prod[WIDTH-1:1]};
  assign hi_nz   = |prod_nx[2*WIDTH-1:WIDTH];
  assign mul_res = {prod_nx[WIDTH-1:0], hi_nz, hi_nz, 1'b0};

  // --------------------------------------------------------------------- FSM
  always_comb begin
    state_nx  = state;
    load_alu  = 1'b0;
    load_mul  = 1'b0;
    start_mul = 1'b0;
    case (state)
      S_MUL: begin
        if (step == LAST_STEP) begin
          load_mul = 1'b1;
          state_nx = S_HOLD;
        end
      end
      default: begin
        if (accept) begin
          if (bus.opcode == OP_MUL) begin
            start_mul = 1'b1;
            state_nx  = S_MUL;
          end else begin
            load_alu = 1'b1;
            state_nx = S_HOLD;
          end
        end else if (state == S_HOLD && bus.out_ready) begin
          state_nx = S_IDLE;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod  <= '0;
      mcand <= '0;
      step  <= '0;
    end else if (start_mul) begin
      prod  <= {{WIDTH{1'b0}}, bus.b};
      mcand <= bus.a;
      step  <= '0;
    end else if (state == S_MUL) begin
      prod  <= prod_nx;
      step  <= step + SHW'(1);
    end
  end

  // ---------------------------------------------------------- result registers
  assign res_nx = load_mul ? mul_res : alu_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q      <= '0;
      negative_q <= 1'b0;
      zero_q     <= 1'b0;
    end else if (load_alu || load_mul) begin
      res_q      <= res_nx;
      negative_q <= res_nx.y[WIDTH-1];
      zero_q     <= (res_nx.y == '0);
    end
  end

  assign bus.y        = res_q.y;
  assign bus.cout     = res_q.cout;
  assign bus.overflow = res_q.overflow;
  assign bus.illegal  = res_q.illegal;
  assign bus.negative = negative_q;
  assign bus.zero     = zero_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe at WIDTH=4 and WIDTH=8, sharing one stimulus
// port set; sel picks which instance is driven and observed.
module tb_alu_pipe;

  typedef struct packed {
    logic [63:0] y;
    logic        c;
    logic        v;
    logic        n;
    logic        z;
    logic        il;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sel = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       cin = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(4)) if4 ();
  alu_pipe_if #(.WIDTH(8)) if8 ();

  assign if4.in_valid  = in_valid & ~sel;
  assign if4.out_ready = out_ready & ~sel;
  assign if4.opcode    = opcode;
  assign if4.a         = a[3:0];
  assign if4.b         = b[3:0];
  assign if4.cin       = cin;
  assign if8.in_valid  = in_valid & sel;
  assign if8.out_ready = out_ready & sel;
  assign if8.opcode    = opcode;
  assign if8.a         = a;
  assign if8.b         = b;
  assign if8.cin       = cin;

  alu_pipe #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  alu_pipe #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

  logic [7:0] o_y;
  logic [4:0] o_flags;
  logic       o_valid, o_ready, o_busy;

  assign o_y     = sel ? if8.y : {4'h0, if4.y};
  assign o_flags = sel ? {if8.cout, if8.overflow, if8.negative, if8.zero, if8.illegal}
                       : {if4.cout, if4.overflow, if4.negative, if4.zero, if4.illegal};
  assign o_valid = sel ? if8.out_valid : if4.out_valid;
  assign o_ready = sel ? if8.in_ready  : if4.in_ready;
  assign o_busy  = sel ? if8.busy      : if4.busy;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: opcode rules evaluated with plain integer arithmetic.
  function automatic exp_t model(input int w, input logic [3:0] op,
                                 input longint unsigned av, input longint unsigned bv,
                                 input bit ci);
    exp_t r;
    longint unsigned mask, full;
    longint sa, sb, s, smax, smin;
    int n;
    mask = (64'd1 << w) - 64'd1;
    smax = (longint'(1) << (w - 1)) - 1;
    smin = -(longint'(1) << (w - 1));
    sa   = av[w-1] ? longint'(av) - (longint'(1) << w) : longint'(av);
    sb   = bv[w-1] ? longint'(bv) - (longint'(1) << w) : longint'(bv);
    n    = int'(bv);
    r    = '0;
    case (op)
      4'd0: if (n == 0) r.y = av;
            else if (n < w) begin r.y = (av << n) & mask; r.c = av[w-n]; end
      4'd1: if (n == 0) r.y = av;
            else if (n < w) begin r.y = av >> n; r.c = av[n-1]; end
      4'd2: if (n == 0) r.y = av;
            else if (n < w) begin full = sa >>> n; r.y = full & mask; r.c = av[n-1]; end
            else r.y = av[w-1] ? mask : 64'd0;
      4'd3: r.y = ~av & mask;
      4'd4: r.y = av & bv;
      4'd5: r.y = av | bv;
      4'd6: r.y = av ^ bv;
      4'd7: begin
        full = av + bv + (ci ? 64'd1 : 64'd0);
        r.y  = full & mask;
        r.c  = full[w];
        s    = sa + sb + (ci ? 1 : 0);
        r.v  = (s > smax) || (s < smin);
      end
      4'd8: begin
        full = av + (~bv & mask) + (ci ? 64'd1 : 64'd0);
        r.y  = full & mask;
        r.c  = full[w];
        s    = sa - sb - 1 + (ci ? 1 : 0);
        r.v  = (s > smax) || (s < smin);
      end
      4'd9: begin
        full = av * bv;
        r.y  = full & mask;
        r.c  = (full >> w) != 0;
        r.v  = r.c;
      end
      default: r.il = 1'b1;
    endcase
    r.n = r.y[w-1];
    r.z = (r.y == 0);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string t);
    int n;
    n = 0;
    while (!o_ready && n < 40) begin tick(); n++; end
    check({t, "_ready_wait"}, 64'(n < 40), 64'd1);
  endtask

  // Issue one op, check latency, result and flags, optionally stall, then consume.
  task automatic run_op(input bit wide, input logic [3:0] op, input logic [7:0] av_in,
                        input logic [7:0] bv_in, input bit ci, input int stall);
    int w, n;
    exp_t e;
    string t;
    logic [7:0] av, bv;
    w  = wide ? 8 : 4;
    av = wide ? av_in : (av_in & 8'h0f);
    bv = wide ? bv_in : (bv_in & 8'h0f);
    t  = $sformatf("w%0d_op%0h_a%0h_b%0h", w, op, av, bv);
    e  = model(w, op, 64'(av), 64'(bv), ci);
    sel = wide; opcode = op; a = av; b = bv; cin = ci; in_valid = 1'b1;
    wait_ready(t);
    tick();
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    if (op == 4'd9) begin
      check({t, "_busy"}, 64'(o_busy), 64'd1);
      check({t, "_ready_in_mul"}, 64'(o_ready), 64'd0);
      n = 0;
      while (!o_valid && n < 40) begin tick(); n++; end
      check({t, "_mul_latency"}, 64'(n), 64'(w));
      check({t, "_busy_done"}, 64'(o_busy), 64'd0);
    end
    check({t, "_valid"}, 64'(o_valid), 64'd1);
    check({t, "_y"}, 64'(o_y), e.y);
    check({t, "_flags"}, 64'(o_flags), 64'({e.c, e.v, e.n, e.z, e.il}));
    if (stall > 0) begin
      repeat (stall) tick();
      check({t, "_hold_y"}, 64'(o_y), e.y);
      check({t, "_hold_ready"}, 64'(o_ready), 64'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({t, "_consumed"}, 64'(o_valid), 64'd0);
    check({t, "_kept_y"}, 64'(o_y), e.y);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [7:0] y_and;
    bit seen;

    // Reset state for both widths.
    #3;
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      check($sformatf("rst%0d_y", s), 64'(o_y), 64'd0);
      check($sformatf("rst%0d_flags", s), 64'(o_flags), 64'd0);
      check($sformatf("rst%0d_valid", s), 64'(o_valid), 64'd0);
      check($sformatf("rst%0d_busy", s), 64'(o_busy), 64'd0);
      check($sformatf("rst%0d_ready", s), 64'(o_ready), 64'd0);
    end
    sel = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", 64'(o_ready), 64'd1);

    // WIDTH=4 directed vectors.
    run_op(1'b0, 4'd0, 8'h1, 8'h1, 1'b0, 0);
    run_op(1'b0, 4'd2, 8'h9, 8'h1, 1'b0, 0);
    run_op(1'b0, 4'd1, 8'h8, 8'h5, 1'b0, 1);
    run_op(1'b0, 4'd7, 8'h7, 8'h1, 1'b0, 0);
    run_op(1'b0, 4'd8, 8'h3, 8'h5, 1'b1, 0);
    run_op(1'b0, 4'd9, 8'h5, 8'h3, 1'b0, 0);
    run_op(1'b0, 4'd9, 8'hf, 8'h3, 1'b0, 2);

    // Backpressure: AND result held for 5 cycles, then same-edge XOR accept.
    sel = 1'b0; opcode = 4'd4; a = 8'hc; b = 8'h6; in_valid = 1'b1;
    wait_ready("bp_and");
    tick();
    y_and  = 8'h4;
    opcode = 4'd6; a = 8'hc; b = 8'ha;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("bp_hold_y_%0d", i), 64'(o_y), 64'(y_and));
      check($sformatf("bp_hold_ready_%0d", i), 64'(o_ready), 64'd0);
    end
    check("bp_hold_flags", 64'(o_flags), 64'd0);
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(o_ready), 64'd1);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    check("bp_xor_valid", 64'(o_valid), 64'd1);
    check("bp_xor_y", 64'(o_y), 64'h6);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_consumed", 64'(o_valid), 64'd0);

    // Illegal opcode, then a legal op clears the flag.
    run_op(1'b0, 4'hc, 8'h3, 8'h7, 1'b0, 0);
    run_op(1'b0, 4'd5, 8'ha, 8'h5, 1'b0, 0);

    // Reset pulsed during the second MUL step.
    sel = 1'b0; opcode = 4'd9; a = 8'h5; b = 8'h3; in_valid = 1'b1;
    wait_ready("rst_mul");
    tick();
    in_valid = 1'b0;
    tick();
    check("rst_mul_busy_before", 64'(o_busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mul_valid", 64'(o_valid), 64'd0);
    check("rst_mul_busy", 64'(o_busy), 64'd0);
    check("rst_mul_y", 64'(o_y), 64'd0);
    check("rst_mul_flags", 64'(o_flags), 64'd0);
    check("rst_mul_ready", 64'(o_ready), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_mul_ready_after", 64'(o_ready), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (o_valid) seen = 1'b1;
      tick();
    end
    check("rst_mul_no_stale", 64'(seen), 64'd0);

    // WIDTH=8 directed vectors.
    run_op(1'b1, 4'd7, 8'h7f, 8'h01, 1'b0, 0);
    run_op(1'b1, 4'd8, 8'h10, 8'h20, 1'b1, 0);
    run_op(1'b1, 4'd9, 8'h10, 8'h10, 1'b0, 0);
    run_op(1'b1, 4'd9, 8'hff, 8'hff, 1'b0, 0);
    run_op(1'b1, 4'd0, 8'h81, 8'h08, 1'b0, 0);
    run_op(1'b1, 4'd0, 8'h81, 8'h01, 1'b0, 0);
    run_op(1'b1, 4'd2, 8'h80, 8'h03, 1'b0, 0);
    run_op(1'b1, 4'd2, 8'h80, 8'h09, 1'b0, 0);
    run_op(1'b1, 4'd1, 8'h81, 8'h07, 1'b0, 0);
    run_op(1'b1, 4'd1, 8'h81, 8'h00, 1'b0, 0);

    // Randomised ops across both widths, biased toward in-range shift amounts.
    for (int i = 0; i < 250; i++) begin
      bit         wide;
      logic [3:0] op;
      logic [7:0] av, bv;
      int         w;
      wide = 1'($urandom_range(0, 1));
      w    = wide ? 8 : 4;
      op   = 4'($urandom_range(0, 11));
      av   = 8'($urandom);
      bv   = 8'($urandom);
      if (op <= 4'd2 && $urandom_range(0, 1) == 1) bv = 8'($urandom_range(0, w + 1));
      run_op(wide, op, av, bv, 1'($urandom), $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor to the team's combinational 4-bit ALU. It keeps the same opcode encoding and the same flag set, and adds ADD/SUB, an iterative multi-cycle MUL, and valid/ready handshakes on input and output.
- Sits between the operand-fetch stage and the writeback stage of the datapath.
- Holds one result; it stalls upstream while that result is unconsumed or while a MUL is in progress.

Parameters:
WIDTH, 4, operand/result width in bits (legal: 2..32)
SHW, $clog2(WIDTH)+1, width of the internal shift-amount compare (derived, not overridable)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
in_valid  in  1  operands/opcode valid
in_ready  out  1  block can accept this cycle
opcode  in  4  operation select
a  in  WIDTH  operand A
b  in  WIDTH  operand B / shift amount
cin  in  1  carry in (ADD/SUB only)
out_valid  out  1  result registers valid
out_ready  in  1  downstream consumes result
y  out  WIDTH  result
cout  out  1  carry / shifted-out bit / MUL high-half-nonzero
overflow  out  1  signed overflow
negative  out  1  y[WIDTH-1]
zero  out  1  y == 0
illegal  out  1  opcode was unassigned
busy  out  1  MUL iteration in progress

Behaviour:
- Reset (rst_n low, asynchronous): y=0, all flags=0, illegal=0, out_valid=0, busy=0, in_ready=0, FSM=IDLE. Any MUL in progress is aborted and its result is never presented. After release: in_ready=1 on the first cycle.
- in_ready = rst_n && !busy && (!out_valid || out_ready), combinational.
- Accept: a rising edge with in_valid && in_ready. opcode, a, b and cin are captured; later input changes are ignored.
- Opcodes:
  - 0000 LL: y=a<<b
  - 0001 LR: y=a>>b
  - 0010 AR: y=arithmetic a>>>b
  - 0011 NOT: y=~a
  - 0100 AND, 0101 OR, 0110 XOR
  - 0111 ADD: a+b+cin
  - 1000 SUB: a+~b+cin (cin=1 gives true subtract; cout=1 means no borrow)
  - 1001 MUL: unsigned, y=low WIDTH bits
  - 1010-1111: illegal
- Shift amount is the full unsigned value of b:
  - b>=WIDTH: LL/LR give 0, AR gives WIDTH copies of a[MSB], cout=0.
  - b=0: y=a, cout=0.
  - Otherwise cout = last bit shifted out.
- Flags:
  - ADD/SUB: overflow = signed overflow.
  - MUL: cout = overflow = (high WIDTH bits of product != 0).
  - Logic ops and shifts: overflow=0. Logic ops: cout=0.
  - All ops: negative=y[MSB], zero=(y==0).
  - Illegal opcode: y=0, zero=1, illegal=1, other flags 0.
  - illegal is 0 for every legal op.
- FSM states IDLE, MUL, HOLD:
  - IDLE: accepting a non-MUL op registers the result and flags at that edge, out_valid=1 next cycle (1-cycle latency), go to HOLD. Accepting MUL clears the accumulator, sets busy=1, goes to MUL.
  - MUL: shift-add, one multiplier bit per cycle, WIDTH cycles. On the WIDTH-th edge after accept: registers loaded, busy=0, out_valid=1, go to HOLD. in_ready=0 throughout.
  - HOLD: out_valid=1; y and flags stable until out_ready=1.
    - out_ready=1 with in_valid=1: back-to-back accept on the same edge; new result next cycle for non-MUL, go to MUL for MUL.
    - out_ready=1 without in_valid: out_valid=0, go to IDLE.
- Output registers change only on the edge that loads a new result; they keep their value after consumption (out_valid=0).
- Arithmetic is computed at WIDTH+1 bits for carry. MUL uses a 2*WIDTH product internally.

Test Plan:
- WIDTH=4, LL a=0001 b=0001 -> y=0010 cout=0 next cycle. AR a=1001 b=0001 -> y=1100 cout=1 negative=1. LR a=1000 b=0101 -> y=0000 zero=1 cout=0.
- ADD a=0111 b=0001 cin=0 -> y=1000 cout=0 overflow=1 negative=1. SUB a=0011 b=0101 cin=1 -> y=1110 cout=0 overflow=0 negative=1.
- MUL a=0101 b=0011 -> busy=1 and in_ready=0 for 4 cycles, then y=1111 cout=0. MUL a=1111 b=0011 -> y=1101 cout=1 overflow=1.
- Backpressure: out_ready=0 for 5 cycles after an AND result -> y/flags stable, in_ready=0, a second in_valid is not accepted. Then out_ready=1 with in_valid=1 (XOR a=1100 b=1010) -> same-edge accept, y=0110 next cycle.
- Illegal opcode 1100 -> y=0000 zero=1 illegal=1. The following legal op (OR a=1010 b=0101 -> 1111) clears illegal.
- rst_n pulsed low mid-MUL (cycle 2 of 4) -> out_valid, busy, y and flags go to 0 immediately. No stale result appears after release. in_ready=1 one cycle after release.
- Repeat the ADD/MUL/shift vectors at WIDTH=8 (e.g. MUL 0x10*0x10 -> y=0x00 cout=1 zero=1; LL b=8 -> y=0).
